// File: rtl/lane_traffic_engine.sv
// lane_traffic_engine: N-lane obstacle engine for the Frogger playfield.
//
// Each lane holds one obstacle that steps one tile every i_Lane_Period base ticks in the
// direction given by i_Lane_Dir, wrapping at the playfield edges. Also produces a one-cycle
// frog/obstacle collision pulse and a registered tile-hit flag for the video mux.
//
// Ports
//   i_Clk            system clock
//   i_Rst_n          synchronous reset, active low
//   i_Run            1 = obstacles move, 0 = frozen (paused/idle)
//   i_Restart        one-cycle pulse: reload initial positions, clear counters
//   i_Lane_Period    8 bits per lane: base ticks per tile step, 0 = lane stopped
//   i_Lane_Dir       1 bit per lane: 1 = +X, 0 = -X
//   i_Frogger_X/Y    frog tile position
//   i_Col_Count_Div  current pixel tile column
//   i_Row_Count_Div  current pixel tile row
//   o_Lane_X         6 bits per lane, lane i at [6i+5:6i]
//   o_Pixel_Hit      registered: scanned tile holds an obstacle
//   o_Collided       one-cycle pulse on a new frog/obstacle overlap
//   o_Collide_Lane   lane index of the last collision (lowest index wins)
module lane_traffic_engine #(
  parameter int unsigned N_LANES      = 5,
  parameter int unsigned GAME_WIDTH   = 14,
  parameter int unsigned FIRST_LANE_Y = 7,
  parameter int unsigned TICK_COUNT   = 1000000,
  parameter int unsigned INIT_X_STEP  = 3
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic                   i_Run,
  input  logic                   i_Restart,
  input  logic [8*N_LANES-1:0]   i_Lane_Period,
  input  logic [N_LANES-1:0]     i_Lane_Dir,
  input  logic [5:0]             i_Frogger_X,
  input  logic [5:0]             i_Frogger_Y,
  input  logic [4:0]             i_Col_Count_Div,
  input  logic [4:0]             i_Row_Count_Div,
  output logic [6*N_LANES-1:0]   o_Lane_X,
  output logic                   o_Pixel_Hit,
  output logic                   o_Collided,
  output logic [2:0]             o_Collide_Lane
);

  localparam int unsigned PsW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(TICK_COUNT - 1);
  localparam logic [5:0] XMax = 6'(GAME_WIDTH - 1);

  function automatic logic [5:0] init_x(input int unsigned lane);
    return 6'((lane * INIT_X_STEP) % GAME_WIDTH);
  endfunction

  function automatic logic [5:0] step_x(input logic [5:0] x, input logic dir);
    if (dir) begin
      return (x == XMax) ? 6'd0 : x + 6'd1;
    end
    return (x == 6'd0) ? XMax : x - 6'd1;
  endfunction

  logic [PsW-1:0] ps_q, ps_d;
  logic           tick;
  logic [5:0]     lane_x_q   [N_LANES];
  logic [5:0]     lane_x_d   [N_LANES];
  logic [7:0]     step_cnt_q [N_LANES];
  logic [7:0]     step_cnt_d [N_LANES];

  logic       overlap;
  logic [2:0] hit_lane;
  logic       pix_match;
  logic       ovl_q;
  logic       collided_q;
  logic [2:0] collide_lane_q;
  logic       pix_hit_q;
  logic       new_hit;

  // Tick is gated by i_Run so a prescaler frozen at its terminal count does not keep firing.
  assign tick = i_Run && (ps_q == PsLast);

  always_comb begin
    ps_d = ps_q;
    if (i_Restart) begin
      ps_d = '0;
    end else if (i_Run) begin
      ps_d = tick ? '0 : ps_q + 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_LANES; i++) begin
      lane_x_d[i]   = lane_x_q[i];
      step_cnt_d[i] = step_cnt_q[i];
      if (i_Restart) begin
        lane_x_d[i]   = init_x(i);
        step_cnt_d[i] = '0;
      end else if (tick) begin
        if (i_Lane_Period[8*i +: 8] == 8'd0) begin
          step_cnt_d[i] = '0;
        end else if ({1'b0, step_cnt_q[i]} + 9'd1 >= {1'b0, i_Lane_Period[8*i +: 8]}) begin
          // >= (not ==) so a period lowered below the running count steps on the next tick
          step_cnt_d[i] = '0;
          lane_x_d[i]   = step_x(lane_x_q[i], i_Lane_Dir[i]);
        end else begin
          step_cnt_d[i] = step_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Frog overlap (lowest lane wins) and scan-tile match against current obstacle positions.
  always_comb begin
    overlap   = 1'b0;
    hit_lane  = 3'd0;
    pix_match = 1'b0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (!overlap && (i_Frogger_X == lane_x_q[i]) &&
          (32'(i_Frogger_Y) == FIRST_LANE_Y + i)) begin
        overlap  = 1'b1;
        hit_lane = 3'(i);
      end
      if ((32'(i_Col_Count_Div) == 32'(lane_x_q[i])) &&
          (32'(i_Row_Count_Div) == FIRST_LANE_Y + i)) begin
        pix_match = 1'b1;
      end
    end
  end

  assign new_hit = i_Run && overlap && !ovl_q;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      ps_q           <= '0;
      ovl_q          <= 1'b0;
      collided_q     <= 1'b0;
      collide_lane_q <= 3'd0;
      pix_hit_q      <= 1'b0;
      for (int unsigned i = 0; i < N_LANES; i++) begin
        lane_x_q[i]   <= init_x(i);
        step_cnt_q[i] <= '0;
      end
    end else begin
      ps_q      <= ps_d;
      pix_hit_q <= pix_match;
      for (int unsigned i = 0; i < N_LANES; i++) begin
        lane_x_q[i]   <= lane_x_d[i];
        step_cnt_q[i] <= step_cnt_d[i];
      end
      if (i_Restart) begin
        // Collide lane deliberately kept so the game FSM can still read the last hit.
        ovl_q      <= 1'b0;
        collided_q <= 1'b0;
      end else begin
        // History only tracks while running; a pause re-arms the collision pulse.
        ovl_q      <= i_Run && overlap;
        collided_q <= new_hit;
        if (new_hit) begin
          collide_lane_q <= hit_lane;
        end
      end
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane_out
    assign o_Lane_X[6*g +: 6] = lane_x_q[g];
  end

  assign o_Pixel_Hit    = pix_hit_q;
  assign o_Collided     = collided_q;
  assign o_Collide_Lane = collide_lane_q;

endmodule

// File: tb/tb_lane_traffic_engine.sv
module tb_lane_traffic_engine;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n;
  logic        i_Run;
  logic        i_Restart;
  logic [39:0] i_Lane_Period;
  logic [4:0]  i_Lane_Dir;
  logic [5:0]  i_Frogger_X;
  logic [5:0]  i_Frogger_Y;
  logic [4:0]  i_Col_Count_Div;
  logic [4:0]  i_Row_Count_Div;
  logic [29:0] o_Lane_X;
  logic        o_Pixel_Hit;
  logic        o_Collided;
  logic [2:0]  o_Collide_Lane;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [29:0] init_pos;

  lane_traffic_engine #(
    .N_LANES     (5),
    .GAME_WIDTH  (14),
    .FIRST_LANE_Y(7),
    .TICK_COUNT  (4),
    .INIT_X_STEP (3)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Rst_n        (i_Rst_n),
    .i_Run          (i_Run),
    .i_Restart      (i_Restart),
    .i_Lane_Period  (i_Lane_Period),
    .i_Lane_Dir     (i_Lane_Dir),
    .i_Frogger_X    (i_Frogger_X),
    .i_Frogger_Y    (i_Frogger_Y),
    .i_Col_Count_Div(i_Col_Count_Div),
    .i_Row_Count_Div(i_Row_Count_Div),
    .o_Lane_X       (o_Lane_X),
    .o_Pixel_Hit    (o_Pixel_Hit),
    .o_Collided     (o_Collided),
    .o_Collide_Lane (o_Collide_Lane)
  );

  always #5 i_Clk = ~i_Clk;

  // Advance n rising edges and settle just after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  function automatic logic [5:0] lx(input int i);
    return o_Lane_X[6*i +: 6];
  endfunction

  task automatic do_restart();
    i_Restart = 1'b1;
    cyc(1);
    i_Restart = 1'b0;
  endtask

  task automatic set_frog(input logic [5:0] x, input logic [5:0] y);
    i_Frogger_X = x;
    i_Frogger_Y = y;
  endtask

  task automatic test_reset();
    int pulses;
    i_Rst_n = 1'b0;
    i_Run   = 1'b0;
    cyc(2);
    i_Rst_n = 1'b1;
    tests_run++;
    if (o_Lane_X !== init_pos) begin
      tests_failed++;
      $display("FAIL reset_lanes got %h want %h", o_Lane_X, init_pos);
    end
    tests_run++;
    if (o_Collided !== 1'b0 || o_Collide_Lane !== 3'd0 || o_Pixel_Hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags got col=%b lane=%0d pix=%b want 0 0 0",
               o_Collided, o_Collide_Lane, o_Pixel_Hit);
    end
    // Frog sits on lane 2 while idle: frozen play must never report a collision.
    set_frog(6'd6, 6'd9);
    pulses = 0;
    repeat (20) begin
      cyc(1);
      if (o_Collided === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL idle_no_collide got %0d pulses want 0", pulses);
    end
    tests_run++;
    if (o_Lane_X !== init_pos) begin
      tests_failed++;
      $display("FAIL idle_frozen got %h want %h", o_Lane_X, init_pos);
    end
    set_frog(6'd0, 6'd0);
  endtask

  task automatic test_lane0_step();
    do_restart();
    i_Lane_Period[7:0] = 8'd1;
    i_Lane_Dir[0]      = 1'b1;
    i_Run              = 1'b1;
    cyc(3);
    tests_run++;
    if (lx(0) !== 6'd0) begin
      tests_failed++;
      $display("FAIL lane0_before_tick got %0d want 0", lx(0));
    end
    cyc(1);
    tests_run++;
    if (lx(0) !== 6'd1) begin
      tests_failed++;
      $display("FAIL lane0_first_step got %0d want 1", lx(0));
    end
    // Steps 2..14: last one wraps 13 -> 0.
    for (int k = 2; k <= 14; k++) begin
      cyc(4);
      tests_run++;
      if (lx(0) !== 6'(k % 14)) begin
        tests_failed++;
        $display("FAIL lane0_step%0d got %0d want %0d", k, lx(0), k % 14);
      end
    end
    i_Run         = 1'b0;
    i_Lane_Period = '0;
    i_Lane_Dir    = '0;
  endtask

  task automatic test_lane1_left();
    do_restart();
    i_Lane_Period[15:8] = 8'd3;
    i_Lane_Dir[1]       = 1'b0;
    i_Run               = 1'b1;
    cyc(11);
    tests_run++;
    if (lx(1) !== 6'd3) begin
      tests_failed++;
      $display("FAIL lane1_pre_step got %0d want 3", lx(1));
    end
    cyc(1);
    tests_run++;
    if (lx(1) !== 6'd2) begin
      tests_failed++;
      $display("FAIL lane1_step got %0d want 2", lx(1));
    end
    cyc(24);
    tests_run++;
    if (lx(1) !== 6'd0) begin
      tests_failed++;
      $display("FAIL lane1_at0 got %0d want 0", lx(1));
    end
    cyc(12);
    tests_run++;
    if (lx(1) !== 6'd13) begin
      tests_failed++;
      $display("FAIL lane1_wrap got %0d want 13", lx(1));
    end
    i_Lane_Period[15:8] = 8'd0;
    cyc(24);
    tests_run++;
    if (lx(1) !== 6'd13) begin
      tests_failed++;
      $display("FAIL lane1_period0_hold got %0d want 13", lx(1));
    end
    // Count to 2 with period 5, then drop period to 2: must step on the next tick.
    i_Lane_Period[15:8] = 8'd5;
    cyc(8);
    tests_run++;
    if (lx(1) !== 6'd13) begin
      tests_failed++;
      $display("FAIL lane1_period5_count got %0d want 13", lx(1));
    end
    i_Lane_Period[15:8] = 8'd2;
    cyc(4);
    tests_run++;
    if (lx(1) !== 6'd12) begin
      tests_failed++;
      $display("FAIL lane1_period_lowered got %0d want 12", lx(1));
    end
    i_Run         = 1'b0;
    i_Lane_Period = '0;
  endtask

  task automatic test_collision();
    int pulses;
    do_restart();
    set_frog(6'd6, 6'd9);
    i_Run = 1'b1;
    cyc(1);
    tests_run++;
    if (o_Collided !== 1'b1 || o_Collide_Lane !== 3'd2) begin
      tests_failed++;
      $display("FAIL collide_first got col=%b lane=%0d want 1 2", o_Collided, o_Collide_Lane);
    end
    pulses = 0;
    repeat (50) begin
      cyc(1);
      if (o_Collided === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL collide_sustained got %0d pulses want 0", pulses);
    end
    set_frog(6'd6, 6'd8);
    cyc(3);
    tests_run++;
    if (o_Collided !== 1'b0) begin
      tests_failed++;
      $display("FAIL collide_off_lane got %b want 0", o_Collided);
    end
    set_frog(6'd6, 6'd9);
    cyc(1);
    tests_run++;
    if (o_Collided !== 1'b1) begin
      tests_failed++;
      $display("FAIL collide_reenter got %b want 1", o_Collided);
    end
    // Pausing clears history, so resuming on the obstacle pulses again.
    i_Run = 1'b0;
    cyc(2);
    i_Run = 1'b1;
    cyc(1);
    tests_run++;
    if (o_Collided !== 1'b1) begin
      tests_failed++;
      $display("FAIL collide_after_pause got %b want 1", o_Collided);
    end
    set_frog(6'd0, 6'd0);
    cyc(2);
    set_frog(6'd3, 6'd8);
    cyc(1);
    tests_run++;
    if (o_Collided !== 1'b1 || o_Collide_Lane !== 3'd1) begin
      tests_failed++;
      $display("FAIL collide_lane1 got col=%b lane=%0d want 1 1", o_Collided, o_Collide_Lane);
    end
    do_restart();
    tests_run++;
    if (o_Collided !== 1'b0 || o_Collide_Lane !== 3'd1) begin
      tests_failed++;
      $display("FAIL restart_keeps_lane got col=%b lane=%0d want 0 1",
               o_Collided, o_Collide_Lane);
    end
    set_frog(6'd0, 6'd0);
    i_Run = 1'b0;
    cyc(1);
  endtask

  task automatic test_pixel();
    logic [4:0] cols [6];
    logic [4:0] rows [6];
    logic       exp  [6];
    cols = '{5'd9, 5'd9, 5'd12, 5'd3, 5'd0, 5'd0};
    rows = '{5'd10, 5'd12, 5'd11, 5'd7, 5'd7, 5'd6};
    exp  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      i_Col_Count_Div = cols[k];
      i_Row_Count_Div = rows[k];
      cyc(1);
      tests_run++;
      if (o_Pixel_Hit !== exp[k]) begin
        tests_failed++;
        $display("FAIL pixel_c%0d_r%0d got %b want %b", cols[k], rows[k], o_Pixel_Hit, exp[k]);
      end
    end
    i_Col_Count_Div = '0;
    i_Row_Count_Div = '0;
  endtask

  task automatic test_restart_tick();
    logic [29:0] moved;
    moved = {6'd12, 6'd9, 6'd6, 6'd4, 6'd1};
    do_restart();
    i_Lane_Period[15:0] = {8'd1, 8'd1};
    i_Lane_Dir[1:0]     = 2'b11;
    i_Run               = 1'b1;
    cyc(4);
    tests_run++;
    if (o_Lane_X !== moved) begin
      tests_failed++;
      $display("FAIL restart_pre_move got %h want %h", o_Lane_X, moved);
    end
    cyc(3);
    i_Restart = 1'b1;
    cyc(1);
    i_Restart = 1'b0;
    tests_run++;
    if (o_Lane_X !== init_pos) begin
      tests_failed++;
      $display("FAIL restart_with_tick got %h want %h", o_Lane_X, init_pos);
    end
    cyc(3);
    tests_run++;
    if (lx(0) !== 6'd0) begin
      tests_failed++;
      $display("FAIL restart_prescaler_clear got %0d want 0", lx(0));
    end
    cyc(1);
    tests_run++;
    if (lx(0) !== 6'd1 || lx(1) !== 6'd4) begin
      tests_failed++;
      $display("FAIL restart_resume got %0d,%0d want 1,4", lx(0), lx(1));
    end
    i_Run         = 1'b0;
    i_Lane_Period = '0;
    i_Lane_Dir    = '0;
  endtask

  task automatic test_reset_mid_collision();
    do_restart();
    i_Run = 1'b1;
    set_frog(6'd6, 6'd9);
    cyc(1);
    tests_run++;
    if (o_Collided !== 1'b1 || o_Collide_Lane !== 3'd2) begin
      tests_failed++;
      $display("FAIL rst_setup got col=%b lane=%0d want 1 2", o_Collided, o_Collide_Lane);
    end
    set_frog(6'd0, 6'd0);
    cyc(2);
    set_frog(6'd6, 6'd9);
    i_Rst_n = 1'b0;
    cyc(1);
    tests_run++;
    if (o_Collided !== 1'b0 || o_Collide_Lane !== 3'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_collision got col=%b lane=%0d want 0 0",
               o_Collided, o_Collide_Lane);
    end
    i_Rst_n = 1'b1;
    cyc(1);
    tests_run++;
    if (o_Collided !== 1'b1 || o_Collide_Lane !== 3'd2) begin
      tests_failed++;
      $display("FAIL rst_release_collide got col=%b lane=%0d want 1 2",
               o_Collided, o_Collide_Lane);
    end
    i_Run = 1'b0;
    set_frog(6'd0, 6'd0);
  endtask

  initial begin
    init_pos        = {6'd12, 6'd9, 6'd6, 6'd3, 6'd0};
    i_Rst_n         = 1'b0;
    i_Run           = 1'b0;
    i_Restart       = 1'b0;
    i_Lane_Period   = '0;
    i_Lane_Dir      = '0;
    i_Frogger_X     = '0;
    i_Frogger_Y     = '0;
    i_Col_Count_Div = '0;
    i_Row_Count_Div = '0;
    test_reset();
    test_lane0_step();
    test_lane1_left();
    test_collision();
    test_pixel();
    test_restart_tick();
    test_reset_mid_collision();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
